// File: rtl/dma_seq_pkg.sv
// Shared definitions for the DMA task sequencer.
//   - Top-level and poller state encodings.
//   - One-hot init task constants and a helper to build them.
//   - Bit positions inside the MM2S/S2MM status registers.
//   - Per-slot status codes written to the bank1 slot table.
package dma_seq_pkg;

  localparam int DMA_INIT_TASK_CNT = 8;

  localparam logic [7:0] TASK_0 = 8'h01;
  localparam logic [7:0] TASK_1 = 8'h02;
  localparam logic [7:0] TASK_2 = 8'h04;
  localparam logic [7:0] TASK_3 = 8'h08;
  localparam logic [7:0] TASK_4 = 8'h10;
  localparam logic [7:0] TASK_5 = 8'h20;
  localparam logic [7:0] TASK_6 = 8'h40;
  localparam logic [7:0] TASK_7 = 8'h80;

  // DMA status register fields: Idle flag and the three error flags
  // (internal, slave, decode).
  localparam int IDLE_BIT = 1;
  localparam int ERR_LO   = 4;
  localparam int ERR_HI   = 6;

  localparam logic [1:0] SLOT_ST_DONE = 2'b01;
  localparam logic [1:0] SLOT_ST_ERR  = 2'b10;
  localparam logic [1:0] SLOT_ST_TMO  = 2'b11;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_INIT     = 3'd1,
    SEQ_INIT_GAP = 3'd2,
    SEQ_POLL     = 3'd3,
    SEQ_SLOT_END = 3'd4,
    SEQ_FINISH   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    PL_IDLE = 2'd0,
    PL_REQ  = 2'd1,
    PL_WAIT = 2'd2
  } poll_state_t;

  function automatic logic [7:0] task_onehot(input logic [2:0] t);
    return 8'h01 << t;
  endfunction

endpackage

// File: rtl/dma_seq_poller.sv
// Polls the MM2S then the S2MM status register until each reports Idle.
// Optional macro: DMA_SEQ_TIMEOUT_EN adds a per-channel limit of 65535
// unsuccessful polls, ending with the timeout status code.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   start            one-cycle pulse, begins with the MM2S channel
//   poll_req/sel     read request (held until poll_ack) and channel select
//   poll_ack/data    read completion and the status register value
//   done/status      one-cycle result pulse with the slot status code
//   dbg_state        current poller state
// Handshake: poll_req stays high with poll_sel stable until the cycle in
// which poll_ack is high; poll_data is only looked at in that cycle.
module dma_seq_poller
  import dma_seq_pkg::*;
#(
  parameter int GLOB_DATA_WIDTH = 32,
  parameter int POLL_GAP        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       poll_req,
  output logic                       poll_sel,
  input  logic                       poll_ack,
  input  logic [GLOB_DATA_WIDTH-1:0] poll_data,
  output logic                       done,
  output logic [1:0]                 status,
  output poll_state_t                dbg_state
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  poll_state_t      state, state_n;
  logic             sel;
  logic [GAP_W-1:0] gap_cnt;
  logic             acked, data_idle, data_err, tmo_hit;
  logic             data_unused;

  assign acked       = (state == PL_REQ) && poll_ack;
  assign data_idle   = poll_data[IDLE_BIT];
  assign data_err    = |poll_data[ERR_HI:ERR_LO];
  assign data_unused = ^poll_data;

`ifdef DMA_SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  // Counts unsuccessful polls on the current channel; the 65535th one ends the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if ((state == PL_IDLE && start) || (acked && !data_err && data_idle)) begin
      tmo_cnt <= '0;
    end else if (acked && !data_err) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
  assign tmo_hit = (tmo_cnt == 16'hFFFE);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= PL_IDLE;
    else        state <= state_n;
  end

  // Error flags win over Idle: a channel that reports both is an error.
  always_comb begin
    state_n = state;
    case (state)
      PL_IDLE: if (start) state_n = PL_REQ;
      PL_REQ: begin
        if (poll_ack) begin
          if (data_err)               state_n = PL_IDLE;
          else if (data_idle && sel)  state_n = PL_IDLE;
          else if (data_idle)         state_n = PL_REQ;
          else if (tmo_hit)           state_n = PL_IDLE;
          else                        state_n = PL_WAIT;
        end
      end
      PL_WAIT: if (gap_cnt == '0) state_n = PL_REQ;
      default: state_n = PL_IDLE;
    endcase
  end

  always_comb begin
    poll_req  = (state == PL_REQ);
    poll_sel  = sel;
    done      = acked && (data_err || (data_idle && sel) || (!data_idle && tmo_hit));
    status    = data_err ? SLOT_ST_ERR : (data_idle ? SLOT_ST_DONE : SLOT_ST_TMO);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel     <= 1'b0;
      gap_cnt <= '0;
    end else begin
      if (state == PL_IDLE && start)                 sel <= 1'b0;
      else if (acked && !data_err && data_idle && !sel) sel <= 1'b1;
      if (acked)                                     gap_cnt <= GAP_W'(POLL_GAP - 1);
      else if (state == PL_WAIT && gap_cnt != '0)    gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

endmodule

// File: rtl/dma_task_sequencer.sv
// Walks the bank1 slot table: for each slot it issues the 8 one-hot init
// tasks to the AXI-lite DMA register writer, polls both DMA channels until
// idle, then writes the slot status and cycle profile back to bank1.
// Optional macro: DMA_SEQ_TIMEOUT_EN (poll timeout, in dma_seq_poller).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ctrl_start, ctrl_slot_cnt  bank0 start pulse and slot count (0 = all)
//   seq_busy/done/err          bank0 run status
//   seq_slot_idx               current slot, selects writer src/dst fields
//   slaveInit, slaveFinInit    one-hot task request / writer completion
//   poll_*                     status register read port
//   slot_wr_en/status/profile  bank1 slot result write strobe and data
// Handshakes: slaveInit holds one task until slaveFinInit equals it, then
// drops to zero for one cycle; poll_req holds until poll_ack.
module dma_task_sequencer
  import dma_seq_pkg::*;
#(
  parameter int BANK1_INDEX_WIDTH   = 3,
  parameter int BANK1_PROFILE_WIDTH = 32,
  parameter int BANK1_STATUS_WIDTH  = 2,
  parameter int DMA_INIT_TASK_CNT   = 8,
  parameter int GLOB_DATA_WIDTH     = 32,
  parameter int POLL_GAP            = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ctrl_start,
  input  logic [BANK1_INDEX_WIDTH-1:0]   ctrl_slot_cnt,
  output logic                           seq_busy,
  output logic                           seq_done,
  output logic                           seq_err,
  output logic [BANK1_INDEX_WIDTH-1:0]   seq_slot_idx,
  output logic [DMA_INIT_TASK_CNT-1:0]   slaveInit,
  input  logic [DMA_INIT_TASK_CNT-1:0]   slaveFinInit,
  output logic                           poll_req,
  output logic                           poll_sel,
  input  logic                           poll_ack,
  input  logic [GLOB_DATA_WIDTH-1:0]     poll_data,
  output logic                           slot_wr_en,
  output logic [BANK1_STATUS_WIDTH-1:0]  slot_status,
  output logic [BANK1_PROFILE_WIDTH-1:0] slot_profile
);

  seq_state_t                     state, state_n;
  logic [2:0]                     task_idx;
  logic [BANK1_INDEX_WIDTH-1:0]   slot_idx, slot_cnt_q;
  logic [BANK1_PROFILE_WIDTH-1:0] prof_cnt;
  logic [BANK1_STATUS_WIDTH-1:0]  end_status;
  logic                           err_q;
  logic                           fin_hit, last_slot, slot_ok;
  logic                           poll_start, poll_done;
  logic [1:0]                     poll_status;
  poll_state_t                    poll_dbg_state;

  assign fin_hit    = (state == SEQ_INIT) && (slaveFinInit == slaveInit);
  assign poll_start = fin_hit && (task_idx == 3'd7);
  // count-1 wraps to all-ones when count is 0, so the last slot is 2^W-1.
  assign last_slot  = (slot_idx == slot_cnt_q - BANK1_INDEX_WIDTH'(1));
  assign slot_ok    = (end_status == BANK1_STATUS_WIDTH'(SLOT_ST_DONE));

  dma_seq_poller #(
    .GLOB_DATA_WIDTH(GLOB_DATA_WIDTH),
    .POLL_GAP       (POLL_GAP)
  ) u_poller (
    .clk      (clk),
    .reset    (reset),
    .start    (poll_start),
    .poll_req (poll_req),
    .poll_sel (poll_sel),
    .poll_ack (poll_ack),
    .poll_data(poll_data),
    .done     (poll_done),
    .status   (poll_status),
    .dbg_state(poll_dbg_state)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEQ_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      SEQ_IDLE:     if (ctrl_start) state_n = SEQ_INIT;
      SEQ_INIT:     if (fin_hit) state_n = (task_idx == 3'd7) ? SEQ_POLL : SEQ_INIT_GAP;
      SEQ_INIT_GAP: state_n = SEQ_INIT;
      SEQ_POLL:     if (poll_done) state_n = SEQ_SLOT_END;
      SEQ_SLOT_END: state_n = (!slot_ok || last_slot) ? SEQ_FINISH : SEQ_INIT;
      SEQ_FINISH:   state_n = SEQ_IDLE;
      default:      state_n = SEQ_IDLE;
    endcase
  end

  always_comb begin
    seq_busy     = (state != SEQ_IDLE) && (state != SEQ_FINISH);
    seq_done     = (state == SEQ_FINISH);
    seq_err      = err_q;
    seq_slot_idx = slot_idx;
    slaveInit    = (state == SEQ_INIT) ? DMA_INIT_TASK_CNT'(task_onehot(task_idx)) : '0;
    slot_wr_en   = (state == SEQ_SLOT_END);
    slot_status  = (state == SEQ_SLOT_END) ? end_status : '0;
    slot_profile = (state == SEQ_SLOT_END) ? prof_cnt : '0;
  end

  // prof_cnt is 1 in the first INIT cycle of a slot, so in SLOT_END it
  // holds the inclusive cycle count of the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      task_idx   <= '0;
      slot_idx   <= '0;
      slot_cnt_q <= '0;
      prof_cnt   <= '0;
      end_status <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (ctrl_start) begin
            slot_cnt_q <= ctrl_slot_cnt;
            slot_idx   <= '0;
            task_idx   <= '0;
            prof_cnt   <= BANK1_PROFILE_WIDTH'(1);
            err_q      <= 1'b0;
          end
        end
        SEQ_INIT, SEQ_INIT_GAP, SEQ_POLL: begin
          if (prof_cnt != '1) prof_cnt <= prof_cnt + BANK1_PROFILE_WIDTH'(1);
          if (fin_hit) task_idx <= task_idx + 3'd1;
          if (state == SEQ_POLL && poll_done) end_status <= BANK1_STATUS_WIDTH'(poll_status);
        end
        SEQ_SLOT_END: begin
          if (!slot_ok) begin
            err_q <= 1'b1;
          end else if (!last_slot) begin
            slot_idx <= slot_idx + BANK1_INDEX_WIDTH'(1);
            task_idx <= '0;
            prof_cnt <= BANK1_PROFILE_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
